entrada_freq_hz: RTL

Decimal keypad entry block producing the PWM frequency word (Hz, 0..10000) that feeds the frequency register and, from there, the LCD " Hz" text renderer. It is the inverse path of the display: the renderer turns binary into digits, and this block turns digits into binary. Key strobes from the debounced button/keypad decoder are buffered as right-aligned BCD digits. On confirm, a sequential BCD-to-binary conversion runs, the result is range-checked, and a new freq_Hz is published with a one-cycle strobe.

---
 rtl/entrada_freq_hz.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/entrada_freq_hz.sv
// Decimal keypad entry: buffers right-aligned BCD keys and converts them to a binary Hz word on confirm.
// Optional inactivity timeout is built only when ENTRADA_TIMEOUT_EN is defined.
module entrada_freq_hz #(
    parameter int unsigned N_DIGITOS      = 5,
    parameter int unsigned FREQ_MAX       = 10000,
    parameter int unsigned FREQ_RESET     = 1000,
    parameter int unsigned TIMEOUT_CICLOS = 50000000
) (
    input  logic        NCLK,
    input  logic        NRST,
    input  logic        digito_valid,
    input  logic [3:0]  digito,
    input  logic        borrar,
    input  logic        limpiar,
    input  logic        confirmar,
    output logic [13:0] freq_Hz,
    output logic        freq_valid,
    output logic        fuera_rango,
    output logic        ocupado,
    output logic [2:0]  n_digitos
);

    localparam int unsigned BUF_W = 4 * N_DIGITOS;
    localparam int unsigned ACC_W = $clog2(10 ** N_DIGITOS);
    localparam int unsigned CNT_W = $clog2(N_DIGITOS + 1);

    typedef enum logic [1:0] {IDLE, CONV, CARGA} estado_t;

    estado_t            r_estado, w_estado_sig;
    logic [BUF_W-1:0]   r_buf, w_buf_sig;
    logic [ACC_W-1:0]   r_acc, w_acc_sig;
    logic [CNT_W-1:0]   r_paso, w_paso_sig;
    logic [2:0]         w_n_sig;
    logic [13:0]        w_freq_sig;
    logic               w_valid_sig, w_fr_sig, w_ocup_sig;
    logic               w_timeout;
    logic               w_digito_ok;

    assign w_digito_ok = digito_valid && (digito <= 4'd9) && (n_digitos < 3'(N_DIGITOS));

`ifdef ENTRADA_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_strobe;

    // Any strobe, even one that ends up ignored, counts as activity.
    assign w_strobe  = digito_valid | borrar | limpiar | confirmar;
    assign w_timeout = (r_estado == IDLE) && (n_digitos != 3'd0) && !w_strobe
                       && (r_to_cnt == TO_W'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            r_to_cnt <= '0;
        end else if ((r_estado != IDLE) || (n_digitos == 3'd0) || w_strobe || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_buf_sig    = r_buf;
        w_acc_sig    = r_acc;
        w_paso_sig   = r_paso;
        w_n_sig      = n_digitos;
        w_freq_sig   = freq_Hz;
        w_valid_sig  = 1'b0;
        w_fr_sig     = 1'b0;
        w_ocup_sig   = ocupado;
        case (r_estado)
            IDLE: begin
                if (limpiar) begin
                    w_buf_sig = '0;
                    w_n_sig   = 3'd0;
                end else if (confirmar) begin
                    w_acc_sig    = '0;
                    w_paso_sig   = '0;
                    w_ocup_sig   = 1'b1;
                    w_estado_sig = CONV;
                end else if (borrar) begin
                    w_buf_sig = {4'd0, r_buf[BUF_W-1:4]};
                    if (n_digitos != 3'd0) begin
                        w_n_sig = n_digitos - 3'd1;
                    end
                end else if (w_digito_ok) begin
                    // A leading zero adds nothing to the value, so it is not stored or counted.
                    if (!((n_digitos == 3'd0) && (digito == 4'd0))) begin
                        w_buf_sig = {r_buf[BUF_W-5:0], digito};
                        w_n_sig   = n_digitos + 3'd1;
                    end
                end else if (w_timeout) begin
                    w_buf_sig = '0;
                    w_n_sig   = 3'd0;
                end
            end
            CONV: begin
                w_acc_sig  = (r_acc << 3) + (r_acc << 1) + ACC_W'(r_buf[BUF_W-1 -: 4]);
                w_buf_sig  = {r_buf[BUF_W-5:0], 4'd0};
                w_paso_sig = r_paso + 1'b1;
                if (r_paso == CNT_W'(N_DIGITOS - 1)) begin
                    w_estado_sig = CARGA;
                end
            end
            CARGA: begin
                if (32'(r_acc) > FREQ_MAX) begin
                    w_freq_sig = 14'(FREQ_MAX);
                    w_fr_sig   = 1'b1;
                end else begin
                    w_freq_sig = r_acc[13:0];
                end
                w_valid_sig  = 1'b1;
                w_n_sig      = 3'd0;
                w_buf_sig    = '0;
                w_ocup_sig   = 1'b0;
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            r_buf       <= '0;
            r_acc       <= '0;
            r_paso      <= '0;
            n_digitos   <= 3'd0;
            freq_Hz     <= 14'(FREQ_RESET);
            freq_valid  <= 1'b0;
            fuera_rango <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            r_buf       <= w_buf_sig;
            r_acc       <= w_acc_sig;
            r_paso      <= w_paso_sig;
            n_digitos   <= w_n_sig;
            freq_Hz     <= w_freq_sig;
            freq_valid  <= w_valid_sig;
            fuera_rango <= w_fr_sig;
            ocupado     <= w_ocup_sig;
        end
    end

endmodule
